operand_bypass_scoreboard: RTL and testbench
============================================

# operand_bypass_scoreboard

Parametrised operand bypass network with an integrated long-latency scoreboard. It is the successor to the two-stage integer forwarding unit. It supplies `NUM_SRC` EX-stage operands, for example rs1/rs2/rs3 for fused multiply-add, from `NUM_FWD` prioritised producer slots or the regfile. It also tracks up to `SB_DEPTH` in-flight multi-cycle results (divider, FPU) and raises an issue stall when an ID-stage source depends on one. It sits between the ID→EX boundary and the EX operand muxes.

## Interface
Parameters:
- `XLEN`, 32, datapath width.
- `NUM_SRC`, 3, source operands per instruction.
- `NUM_FWD`, 3, forward slots. Slot 0 is nearest/highest priority.
- `SB_DEPTH`, 4, scoreboard entries.
- `MAX_LAT`, 16, maximum long-latency op latency in cycles. `LW = $clog2(MAX_LAT+1)`.

Ports:
- `i_clk` in 1: clock.
- `i_rst` in 1: reset, synchronous, active-high.
- `i_stall` in 1: pipeline stall; holds registered selects.
- `i_flush` in 1: kill in-flight long-latency ops.
- `i_src_reg_early` in `NUM_SRC`×5: ID-stage source register indices.
- `i_src_used` in `NUM_SRC`: per-source valid mask.
- `i_pre_valid` in `NUM_FWD`: producer that will occupy slot k next cycle writes an int reg.
- `i_pre_rd` in `NUM_FWD`×5: that producer's rd.
- `i_fwd_data` in `NUM_FWD`×`XLEN`: current slot k result.
- `i_rf_data` in `NUM_SRC`×`XLEN`: regfile data registered at ID→EX.
- `i_rf_is_x0` in `NUM_SRC`: registered x0 flags.
- `i_ll_issue` in 1: long-latency op issues this cycle.
- `i_ll_rd` in 5: its rd.
- `i_ll_lat` in `LW`: its latency, 1..`MAX_LAT`.
- `o_src_value` out `NUM_SRC`×`XLEN`: EX operands.
- `o_hazard_stall` out 1: ID source depends on a busy entry.
- `o_sb_full` out 1: no free entry.
- `o_sb_count` out `$clog2(SB_DEPTH+1)`: busy entries.

## Operation
- **Select registration.** When `~i_stall`, for each src i and slot k: `sel[i][k] <= i_pre_valid[k] && i_pre_rd[k]!=0 && i_pre_rd[k]==i_src_reg_early[i]`. Selects hold while stalled.
- **Operand mux.** Combinational. Output is `i_fwd_data[k]` for the lowest k with `sel[i][k]`. Otherwise it is 0 if `i_rf_is_x0[i]`, else `i_rf_data[i]`.
- **Scoreboard entries.** Each entry holds `{valid, rd, cnt[LW-1:0]}`.
- **Allocation.** `i_ll_issue` with `i_ll_rd!=0` allocates the lowest-index free entry with `cnt=i_ll_lat`. rd=0 allocates nothing.
- **Countdown.** Every valid entry decrements `cnt` each cycle, regardless of `i_stall`, because latency is wall-clock. The entry that decrements from 1 to 0 is invalid next cycle. The producer must present its result in a forward slot on that cycle.
- **Duplicate rd.** A second issue to an rd already tracked allocates a separate entry. The stall persists until both entries retire.
- **Hazard.** `o_hazard_stall` = OR over i of `i_src_used[i] && i_src_reg_early[i]!=0 &&` a valid entry has a matching rd. It is combinational from state and inputs.
- **Issue when full.** Issuing while `o_sb_full` is a protocol violation. The request is dropped and a simulation assertion fires.
- **Same-cycle free and issue.** An entry freed this cycle is not reusable until the next cycle. Fullness is evaluated on current state.
- **Flush.** `i_flush` invalidates all entries next cycle and has priority over a same-cycle issue. Selects are unaffected.

## Timing
- **Reset values.** All selects are 0 and all entries invalid. `o_hazard_stall=0`, `o_sb_full=0`, `o_sb_count=0`. `o_src_value` passes regfile/x0 data. Reset mid-operation discards entries and selects in one cycle.
- **Latency.**
  - Select: 1 cycle (registered from early indices).
  - Operand mux: 0 cycles.
  - `o_sb_count`/`o_sb_full`: reflect state registered at the previous edge.
- **Stall release.** An op issued at cycle T with latency L keeps the stall high for dependents through cycle T+L. The dependent issues at T+L+1, with its result selected from the slot.
- **Countdown wrap.** `cnt` never wraps: 0 is terminal. `i_ll_lat=0` is treated as 1.

## Configuration
- **`FROST_FWD_SCOREBOARD_EN` defined:** scoreboard logic present as described.
- **Undefined:** no entries are built. `o_hazard_stall`, `o_sb_full` and `o_sb_count` are tied to 0, and `i_ll_*`/`i_flush` are ignored. The bypass mux is unchanged.

## Test plan
- **Slot priority.** Slot 0 and slot 2 both target x5, src0=x5 → `o_src_value[0]` equals `i_fwd_data[0]` (0xAAAA_0001), not slot 2.
- **x0.** `i_pre_rd=0` with src0=x0 and `i_rf_data=0xDEAD` → selects stay 0 and the output is 0.
- **Stall hold.** With a select set for x7, assert `i_stall` for 3 cycles while `i_pre_rd` changes to x9 → the x7 select is held and the output tracks `i_fwd_data[k]` every cycle.
- **Scoreboard stall.** Issue rd=x3, lat=4 at T; ID src1=x3 → stall high T+1..T+4 and low at T+5. `o_sb_count` is 1 from T+1 and returns to 0 at T+5.
- **Fill and flush.** Issue 4 ops with lat=10 → `o_sb_full=1`. A fifth issue is dropped and the assertion fires. Then `i_flush` → count 0 and stall low next cycle.
- **Reset during busy.** Reset with 2 busy entries → all outputs at reset values next cycle, and a subsequent dependent source does not stall.

Source files
------------

// File: rtl/operand_bypass_scoreboard.sv
// Operand bypass mux with registered forward selects and a long-latency scoreboard.
// Scoreboard is built only when FROST_FWD_SCOREBOARD_EN is defined.
module operand_bypass_scoreboard #(
  parameter  int XLEN     = 32,
  parameter  int NUM_SRC  = 3,
  parameter  int NUM_FWD  = 3,
  parameter  int SB_DEPTH = 4,
  parameter  int MAX_LAT  = 16,
  localparam int LW       = $clog2(MAX_LAT + 1),
  localparam int CW       = $clog2(SB_DEPTH + 1)
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_stall,
  input  logic                    i_flush,
  input  logic [NUM_SRC*5-1:0]    i_src_reg_early,
  input  logic [NUM_SRC-1:0]      i_src_used,
  input  logic [NUM_FWD-1:0]      i_pre_valid,
  input  logic [NUM_FWD*5-1:0]    i_pre_rd,
  input  logic [NUM_FWD*XLEN-1:0] i_fwd_data,
  input  logic [NUM_SRC*XLEN-1:0] i_rf_data,
  input  logic [NUM_SRC-1:0]      i_rf_is_x0,
  input  logic                    i_ll_issue,
  input  logic [4:0]              i_ll_rd,
  input  logic [LW-1:0]           i_ll_lat,
  output logic [NUM_SRC*XLEN-1:0] o_src_value,
  output logic                    o_hazard_stall,
  output logic                    o_sb_full,
  output logic [CW-1:0]           o_sb_count
);

  logic [NUM_SRC-1:0][NUM_FWD-1:0] sel_q;
  logic [NUM_SRC-1:0][NUM_FWD-1:0] sel_d;
  logic [XLEN-1:0]                 val;

  always_comb begin
    sel_d = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      for (int k = 0; k < NUM_FWD; k++) begin
        sel_d[i][k] = i_pre_valid[k]
                   && (i_pre_rd[k*5 +: 5] != 5'd0)
                   && (i_pre_rd[k*5 +: 5] == i_src_reg_early[i*5 +: 5]);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sel_q <= '0;
    end else if (!i_stall) begin
      sel_q <= sel_d;
    end
  end

  // Walk slots from farthest to nearest so the lowest index wins.
  always_comb begin
    o_src_value = '0;
    val = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      val = i_rf_is_x0[i] ? '0 : i_rf_data[i*XLEN +: XLEN];
      for (int k = NUM_FWD - 1; k >= 0; k--) begin
        if (sel_q[i][k]) val = i_fwd_data[k*XLEN +: XLEN];
      end
      o_src_value[i*XLEN +: XLEN] = val;
    end
  end

`ifdef FROST_FWD_SCOREBOARD_EN
  logic [SB_DEPTH-1:0]          vld_q;
  logic [SB_DEPTH-1:0][4:0]     rd_q;
  logic [SB_DEPTH-1:0][LW-1:0]  cnt_q;
  logic [SB_DEPTH-1:0]          alloc_oh;
  logic                         found;
  logic                         req;
  logic [LW-1:0]                lat_eff;

  assign req     = i_ll_issue && (i_ll_rd != 5'd0) && !i_flush;
  assign lat_eff = (i_ll_lat == '0) ? LW'(1) : i_ll_lat;

  // Free slots are judged on current state, so a retiring entry waits a cycle.
  always_comb begin
    alloc_oh = '0;
    found    = 1'b0;
    for (int e = 0; e < SB_DEPTH; e++) begin
      if (!vld_q[e] && !found) begin
        alloc_oh[e] = 1'b1;
        found       = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      vld_q <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (i_flush) begin
      vld_q <= '0;
      cnt_q <= '0;
    end else begin
      for (int e = 0; e < SB_DEPTH; e++) begin
        if (vld_q[e]) begin
          if (cnt_q[e] <= LW'(1)) begin
            vld_q[e] <= 1'b0;
            cnt_q[e] <= '0;
          end else begin
            cnt_q[e] <= cnt_q[e] - LW'(1);
          end
        end else if (req && alloc_oh[e]) begin
          vld_q[e] <= 1'b1;
          rd_q[e]  <= i_ll_rd;
          cnt_q[e] <= lat_eff;
        end
      end
    end
  end

  always_comb begin
    o_sb_count = '0;
    for (int e = 0; e < SB_DEPTH; e++) begin
      o_sb_count = o_sb_count + CW'(vld_q[e]);
    end
  end

  assign o_sb_full = &vld_q;

  always_comb begin
    o_hazard_stall = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      for (int e = 0; e < SB_DEPTH; e++) begin
        if (i_src_used[i] && (i_src_reg_early[i*5 +: 5] != 5'd0)
            && vld_q[e] && (rd_q[e] == i_src_reg_early[i*5 +: 5])) begin
          o_hazard_stall = 1'b1;
        end
      end
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      assert (!(i_ll_issue && (i_ll_rd != 5'd0) && o_sb_full))
        else $warning("long-latency issue while scoreboard full, dropped");
    end
  end
`endif
`else
  logic unused_sb;
  assign unused_sb      = ^{i_flush, i_src_used, i_ll_issue, i_ll_rd, i_ll_lat};
  assign o_hazard_stall = 1'b0;
  assign o_sb_full      = 1'b0;
  assign o_sb_count     = '0;
`endif

endmodule

// File: tb/tb_operand_bypass_scoreboard.sv
// Directed bench for operand_bypass_scoreboard.
// Expected values are queued at drive time and popped at each check.
module tb_operand_bypass_scoreboard;

  localparam int XLEN = 32;
  localparam int NS   = 3;
  localparam int NF   = 3;
  localparam int LW   = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic             stall;
  logic             flush;
  logic [NS*5-1:0]  src_reg;
  logic [NS-1:0]    src_used;
  logic [NF-1:0]    pre_valid;
  logic [NF*5-1:0]  pre_rd;
  logic [NF*XLEN-1:0] fwd_data;
  logic [NS*XLEN-1:0] rf_data;
  logic [NS-1:0]    rf_x0;
  logic             ll_issue;
  logic [4:0]       ll_rd;
  logic [LW-1:0]    ll_lat;
  logic [NS*XLEN-1:0] src_value;
  logic             hz;
  logic             full;
  logic [2:0]       count;

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  operand_bypass_scoreboard dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_stall         (stall),
    .i_flush         (flush),
    .i_src_reg_early (src_reg),
    .i_src_used      (src_used),
    .i_pre_valid     (pre_valid),
    .i_pre_rd        (pre_rd),
    .i_fwd_data      (fwd_data),
    .i_rf_data       (rf_data),
    .i_rf_is_x0      (rf_x0),
    .i_ll_issue      (ll_issue),
    .i_ll_rd         (ll_rd),
    .i_ll_lat        (ll_lat),
    .o_src_value     (src_value),
    .o_hazard_stall  (hz),
    .o_sb_full       (full),
    .o_sb_count      (count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic want(input logic [31:0] e);
    exp_q.push_back(e);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $error("FAIL %s: no expected value queued, observed %h", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e)
        else begin
          fails++;
          $error("FAIL %s: observed %h expected %h", tag, obs, e);
        end
    end
  endtask

  task automatic set_src(input int i, input logic [4:0] r);
    src_reg[i*5 +: 5] = r;
  endtask

  task automatic set_pre(input int k, input logic [4:0] r);
    pre_rd[k*5 +: 5] = r;
  endtask

  task automatic set_fwd(input int k, input logic [31:0] d);
    fwd_data[k*XLEN +: XLEN] = d;
  endtask

  task automatic set_rf(input int i, input logic [31:0] d, input logic z);
    rf_data[i*XLEN +: XLEN] = d;
    rf_x0[i] = z;
  endtask

  function automatic logic [31:0] sv(input int i);
    return src_value[i*XLEN +: XLEN];
  endfunction

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    src_reg = '0; src_used = '0; pre_valid = '0; pre_rd = '0;
    fwd_data = '0; rf_data = '0; rf_x0 = '0;
    ll_issue = 1'b0; ll_rd = '0; ll_lat = '0;
    set_rf(0, 32'h1111_0000, 1'b0);
    set_rf(1, 32'h2222_0000, 1'b0);
    set_rf(2, 32'h3333_0000, 1'b0);
    tick(); tick();
    want(32'h1111_0000); want(0); want(0); want(0);
    settle();
    chk("reset_src0", sv(0));
    chk("reset_count", 32'(count));
    chk("reset_full", 32'(full));
    chk("reset_stall", 32'(hz));
    rst = 1'b0;
    tick();

    // slot priority
    set_src(0, 5); set_src(1, 6); set_src(2, 9);
    pre_valid = 3'b111;
    set_pre(0, 5); set_pre(1, 9); set_pre(2, 5);
    tick();
    pre_valid = '0;
    set_fwd(0, 32'hAAAA_0001);
    set_fwd(1, 32'hBBBB_0002);
    set_fwd(2, 32'hCCCC_0003);
    want(32'hAAAA_0001); want(32'h2222_0000); want(32'hBBBB_0002);
    settle();
    chk("prio_src0", sv(0));
    chk("prio_src1_rf", sv(1));
    chk("prio_src2_slot1", sv(2));

    // x0 never forwards
    tick();
    set_src(0, 0);
    pre_valid = 3'b111;
    set_pre(0, 0); set_pre(1, 0); set_pre(2, 0);
    set_rf(0, 32'h0000_DEAD, 1'b1);
    tick();
    pre_valid = '0;
    want(0); want(32'h3333_0000);
    settle();
    chk("x0_zero", sv(0));
    chk("x0_src2_rf", sv(2));
    rf_x0[0] = 1'b0;
    want(32'h0000_DEAD);
    #1;
    chk("x0_nosel", sv(0));

    // stall holds select
    tick();
    set_src(0, 7);
    pre_valid = 3'b001;
    set_pre(0, 7);
    tick();
    stall = 1'b1;
    set_pre(0, 9);
    for (int j = 0; j < 3; j++) begin
      tick();
      set_fwd(0, 32'h7000_0000 + 32'(j));
      want(32'h7000_0000 + 32'(j));
      settle();
      chk("stall_hold", sv(0));
    end
    tick();
    stall = 1'b0;
    set_rf(0, 32'h0000_7777, 1'b0);
    tick();
    pre_valid = '0;
    want(32'h0000_7777);
    settle();
    chk("stall_release", sv(0));

`ifdef FROST_FWD_SCOREBOARD_EN
    // scoreboard stall window
    tick();
    ll_issue = 1'b1; ll_rd = 3; ll_lat = 4;
    set_src(1, 3); src_used = 3'b010;
    want(0); want(0);
    settle();
    chk("sb_issue_stall", 32'(hz));
    chk("sb_issue_count", 32'(count));
    tick();
    ll_issue = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      want((c <= 4) ? 1 : 0);
      want((c <= 4) ? 1 : 0);
      settle();
      chk("sb_stall_win", 32'(hz));
      chk("sb_count_win", 32'(count));
      tick();
    end
    src_used = '0;

    // fill then flush
    for (int j = 0; j < 4; j++) begin
      ll_issue = 1'b1; ll_rd = 5'(10 + j); ll_lat = 10;
      tick();
    end
    ll_issue = 1'b0;
    want(4); want(1);
    settle();
    chk("fill_count", 32'(count));
    chk("fill_full", 32'(full));
    tick();
    ll_issue = 1'b1; ll_rd = 14; ll_lat = 10;
    set_src(0, 14); src_used = 3'b001;
    tick();
    ll_issue = 1'b0;
    want(4); want(0);
    settle();
    chk("drop_count", 32'(count));
    chk("drop_stall", 32'(hz));
    set_src(0, 10);
    want(1);
    #1;
    chk("full_hazard", 32'(hz));
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    want(0); want(0); want(0);
    settle();
    chk("flush_count", 32'(count));
    chk("flush_full", 32'(full));
    chk("flush_stall", 32'(hz));

    // reset while busy
    tick();
    src_used = '0;
    ll_issue = 1'b1; ll_rd = 20; ll_lat = 8;
    tick();
    ll_rd = 21;
    tick();
    ll_issue = 1'b0;
    set_src(0, 20); src_used = 3'b001;
    want(2); want(1);
    settle();
    chk("busy_count", 32'(count));
    chk("busy_stall", 32'(hz));
    tick();
    pre_valid = 3'b001; set_pre(0, 22); set_src(2, 22);
    set_rf(2, 32'h2222_0002, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    pre_valid = '0;
    want(0); want(0); want(0); want(32'h2222_0002);
    settle();
    chk("rst_count", 32'(count));
    chk("rst_full", 32'(full));
    chk("rst_stall", 32'(hz));
    chk("rst_sel", sv(2));
    tick();
    want(0);
    settle();
    chk("rst_dep_stall", 32'(hz));
`else
    // scoreboard absent: outputs tied low
    tick();
    ll_issue = 1'b1; ll_rd = 3; ll_lat = 4;
    set_src(1, 3); src_used = 3'b010;
    tick();
    ll_issue = 1'b0;
    for (int c = 0; c < 3; c++) begin
      want(0); want(0); want(0);
      settle();
      chk("nosb_stall", 32'(hz));
      chk("nosb_count", 32'(count));
      chk("nosb_full", 32'(full));
      tick();
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
